bitops_coproc: RTL

- Parametrised successor to the single-instruction custom-op coprocessor on the CORE-V eXtension interface (XIF).
- Accepts up to DEPTH outstanding offloaded instructions in an in-order queue and honours commit/kill per instruction ID.
- Executes bit-manipulation ops on an iterative datapath that processes CHUNK bits per cycle, and returns results over the XIF result channel.
- Sits beside the cv32e40x core; issue/commit/result signals are a flattened XIF subset.

---
 rtl/bitops_coproc_pkg.sv | 34 +++
 rtl/bitops_exec.sv | 109 ++++++++++
 rtl/bitops_coproc.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bitops_coproc_pkg.sv
// Shared types for the bit-manipulation XIF coprocessor: funct3 codes, op and FSM enums,
// and the pending-instruction queue entry.
package bitops_coproc_pkg;

    localparam int XLEN     = 32;
    localparam int ID_WIDTH = 4;

    localparam logic [2:0] FUNCT3_CNTB = 3'b000;
    localparam logic [2:0] FUNCT3_CLZ  = 3'b001;
    localparam logic [2:0] FUNCT3_BREV = 3'b010;

    typedef enum logic [1:0] {
        OP_CNTB = 2'd0,
        OP_CLZ  = 2'd1,
        OP_BREV = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        RESULT = 2'd2
    } fsm_e;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [4:0]          rd;
        op_e                 op;
        logic [XLEN-1:0]     rs0;
        logic [XLEN-1:0]     rs1;
        logic                committed;
        logic                killed;
    } entry_t;

endpackage

// File: rtl/bitops_exec.sv
// Iterative CHUNK-bit datapath: start loads operands, done is high during the last of N
// processing cycles; result_o is final from the cycle after done.
module bitops_exec
    import bitops_coproc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  op_e             op_i,
    input  logic [XLEN-1:0] rs0_i,
    input  logic [XLEN-1:0] rs1_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int N  = XLEN / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    logic            r_active;
    logic            r_found;
    logic [KW-1:0]   r_k;
    op_e             r_op;
    logic [XLEN-1:0] r_rs0;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_acc;

    int              w_lo;
    int              w_hi;
    logic [CHUNK-1:0] w_and_chunk;
    logic [CHUNK-1:0] w_msb_chunk;
    logic [CHUNK-1:0] w_lsb_chunk;

    function automatic int popcnt(input logic [CHUNK-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < CHUNK; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int clz_chunk(input logic [CHUNK-1:0] v);
        int  n;
        bit  stop;
        n    = 0;
        stop = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (!stop) begin
                if (v[i]) stop = 1'b1;
                else      n++;
            end
        end
        return n;
    endfunction

    function automatic logic [CHUNK-1:0] rev_chunk(input logic [CHUNK-1:0] v);
        logic [CHUNK-1:0] r;
        for (int i = 0; i < CHUNK; i++) r[i] = v[CHUNK-1-i];
        return r;
    endfunction

    // w_hi doubles as the CLZ scan position and the BREV mirror position of chunk k
    always_comb begin
        w_lo        = CHUNK * int'(r_k);
        w_hi        = CHUNK * (N - 1 - int'(r_k));
        w_lsb_chunk = r_rs0[w_lo +: CHUNK];
        w_and_chunk = r_rs0[w_lo +: CHUNK] & r_rs1[w_lo +: CHUNK];
        w_msb_chunk = r_rs0[w_hi +: CHUNK];
    end

    assign done_o   = r_active && (r_k == KW'(N - 1));
    assign result_o = r_acc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_active <= 1'b0;
            r_found  <= 1'b0;
            r_k      <= '0;
        end else if (start_i) begin
            r_active <= 1'b1;
            r_found  <= 1'b0;
            r_k      <= '0;
        end else if (r_active) begin
            r_k <= r_k + 1'b1;
            if (done_o) r_active <= 1'b0;
            if (r_op == OP_CLZ && w_msb_chunk != '0) r_found <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (start_i) begin
            r_op  <= op_i;
            r_rs0 <= rs0_i;
            r_rs1 <= rs1_i;
            r_acc <= '0;
        end else if (r_active) begin
            case (r_op)
                OP_CNTB: r_acc <= r_acc + XLEN'(popcnt(w_and_chunk));
                OP_CLZ: begin
                    if (!r_found) r_acc <= r_acc + XLEN'(clz_chunk(w_msb_chunk));
                end
                OP_BREV: r_acc[w_hi +: CHUNK] <= rev_chunk(w_lsb_chunk);
                default: r_acc <= r_acc;
            endcase
        end
    end

endmodule

// File: rtl/bitops_coproc.sv
// XIF bit-manipulation coprocessor: in-order DEPTH-entry queue with commit/kill, FSM driving
// bitops_exec. Define BITOPS_COPROC_PERF_EN to add retired/killed performance counters.
module bitops_coproc
    import bitops_coproc_pkg::*;
#(
    parameter int         XLEN     = 32,
    parameter int         ID_WIDTH = 4,
    parameter int         DEPTH    = 4,
    parameter int         CHUNK    = 8,
    parameter logic [6:0] OPCODE   = 7'b0001011
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [XLEN-1:0]     issue_rs0_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic                busy_o
`ifdef BITOPS_COPROC_PERF_EN
    ,
    output logic [31:0]         perf_retired_o,
    output logic [31:0]         perf_killed_o
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    entry_t          r_q [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    fsm_e            r_state;

    fsm_e            w_state_nxt;
    entry_t          w_head;
    entry_t          w_new;
    logic            w_head_vld;
    logic            w_enq;
    logic            w_pop;
    logic            w_kill_pop;
    logic            w_start;
    logic            w_done;
    logic            w_f3_ok;
    logic [XLEN-1:0] w_exec_res;
    logic            w_unused;

    assign w_unused = ^{issue_instr_i[31:15]};

    assign w_f3_ok = (issue_instr_i[14:12] == FUNCT3_CNTB) ||
                     (issue_instr_i[14:12] == FUNCT3_CLZ)  ||
                     (issue_instr_i[14:12] == FUNCT3_BREV);

    assign issue_accept_o    = issue_valid_i && (issue_instr_i[6:0] == OPCODE) && w_f3_ok;
    assign issue_writeback_o = issue_accept_o && (issue_instr_i[11:7] != 5'd0);
    assign issue_ready_o     = (r_count != CW'(DEPTH));
    assign w_enq             = issue_valid_i && issue_ready_o && issue_accept_o;

    assign w_head     = r_q[r_rptr];
    assign w_head_vld = r_vld[r_rptr];

    // A commit arriving with its own issue lands directly in the new entry
    always_comb begin
        w_new.id        = issue_id_i;
        w_new.rd        = issue_instr_i[11:7];
        w_new.rs0       = issue_rs0_i;
        w_new.rs1       = issue_rs1_i;
        w_new.committed = commit_valid_i && (commit_id_i == issue_id_i) && !commit_kill_i;
        w_new.killed    = commit_valid_i && (commit_id_i == issue_id_i) && commit_kill_i;
        case (issue_instr_i[14:12])
            FUNCT3_CNTB: w_new.op = OP_CNTB;
            FUNCT3_CLZ:  w_new.op = OP_CLZ;
            default:     w_new.op = OP_BREV;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_pop       = 1'b0;
        w_kill_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_head_vld && w_head.killed) begin
                    w_pop      = 1'b1;
                    w_kill_pop = 1'b1;
                end else if (w_head_vld && w_head.committed) begin
                    w_start     = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (w_done) w_state_nxt = RESULT;
            end
            RESULT: begin
                if (result_ready_i) begin
                    w_pop       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_vld   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            if (w_enq) begin
                r_vld[r_wptr] <= 1'b1;
                r_wptr        <= r_wptr + 1'b1;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid_i && r_vld[i] && (r_q[i].id == commit_id_i)) begin
                if (commit_kill_i) r_q[i].killed    <= 1'b1;
                else               r_q[i].committed <= 1'b1;
            end
        end
        if (w_enq) r_q[r_wptr] <= w_new;
    end

    bitops_exec #(
        .XLEN  (XLEN),
        .CHUNK (CHUNK)
    ) u_exec (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (w_start),
        .op_i     (w_head.op),
        .rs0_i    (w_head.rs0),
        .rs1_i    (w_head.rs1),
        .done_o   (w_done),
        .result_o (w_exec_res)
    );

    assign result_valid_o = (r_state == RESULT);
    assign result_id_o    = result_valid_o ? w_head.id : '0;
    assign result_rd_o    = result_valid_o ? w_head.rd : '0;
    assign result_we_o    = result_valid_o && (w_head.rd != 5'd0);
    assign result_data_o  = result_valid_o ? w_exec_res : '0;
    assign busy_o         = (r_count != '0) || (r_state != IDLE);

`ifdef BITOPS_COPROC_PERF_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_killed;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_retired <= '0;
            r_perf_killed  <= '0;
        end else begin
            if (result_valid_o && result_ready_i) r_perf_retired <= r_perf_retired + 1'b1;
            if (w_kill_pop)                       r_perf_killed  <= r_perf_killed + 1'b1;
        end
    end

    assign perf_retired_o = r_perf_retired;
    assign perf_killed_o  = r_perf_killed;
`endif

endmodule
